fir_mc_filter: RTL and testbench

Parametrised, time-multiplexed multi-channel FIR filter. It is the successor of the single-channel 128-tap filter, with configurable data, coefficient and tap widths and counts. It adds a valid/ready input handshake, per-channel sample histories and an output-valid strobe. Output rounding, saturation and overflow flagging are new behaviours. It sits between the sample source (ADC/deserialiser) and the output sink, and reads coefficients from an external synchronous ROM with 1-cycle latency.

---
 rtl/fir_mc_filter.sv | 137 +++++++++++++
 tb/tb_fir_mc_filter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fir_mc_filter.sv
// Time-multiplexed multi-channel FIR: one MAC per cycle over NTAPS taps per sample,
// with per-channel histories, round-half-up output scaling and saturation.
module fir_mc_filter #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 18,
  parameter int unsigned NTAPS     = 128,
  parameter int unsigned NCH       = 2,
  parameter int unsigned OUT_SHIFT = 16,
  localparam int unsigned CHW      = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int unsigned AW       = $clog2(NTAPS),
  localparam int unsigned ACC_W    = DATA_W + COEF_W + AW
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     din_valid,
  output logic                     din_ready,
  input  logic [CHW-1:0]           din_ch,
  input  logic signed [DATA_W-1:0] datain,
  output logic [AW-1:0]            coeffaddress,
  input  logic signed [COEF_W-1:0] coeff,
  output logic                     dout_valid,
  output logic [CHW-1:0]           dout_ch,
  output logic signed [DATA_W-1:0] dataout,
  output logic                     overflow
);

  localparam int unsigned PW = DATA_W + COEF_W;
  localparam logic signed [ACC_W:0] ONE  = (ACC_W+1)'(1);
  localparam logic signed [ACC_W:0] RND  = (ONE << OUT_SHIFT) >>> 1;
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0]     DMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]     DMIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, DRAIN} state_t;

  state_t                   state;
  logic [AW-1:0]            k;
  logic [1:0]               drain_cnt;
  logic [CHW-1:0]           ch;
  logic signed [DATA_W-1:0] hist [NCH][NTAPS];
  logic signed [DATA_W-1:0] sample_q;
  logic signed [PW-1:0]     prod_q;
  logic signed [ACC_W-1:0]  acc;
  logic                     s1_valid;
  logic                     p_valid;

  logic                     ch_ok_c;
  logic signed [ACC_W:0]    sum_c;
  logic signed [ACC_W:0]    rounded_c;
  logic [DATA_W-1:0]        sat_c;
  logic                     clipped_c;

  // Ready is a decode of the registered state, forced low while reset is held.
  assign din_ready    = (state == IDLE) && !reset;
  assign coeffaddress = k;
  assign ch_ok_c      = ({1'b0, din_ch} < (CHW+1)'(NCH));

  // Round half up, arithmetic shift, then clip to the output range.
  always_comb begin
    sum_c     = (ACC_W+1)'(acc) + RND;
    rounded_c = sum_c >>> OUT_SHIFT;
    sat_c     = DATA_W'(rounded_c);
    clipped_c = 1'b0;
    if (rounded_c > MAXV) begin
      sat_c     = DMAX;
      clipped_c = 1'b1;
    end else if (rounded_c < MINV) begin
      sat_c     = DMIN;
      clipped_c = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      k          <= '0;
      drain_cnt  <= '0;
      ch         <= '0;
      sample_q   <= '0;
      prod_q     <= '0;
      acc        <= '0;
      s1_valid   <= 1'b0;
      p_valid    <= 1'b0;
      dout_valid <= 1'b0;
      dout_ch    <= '0;
      dataout    <= '0;
      overflow   <= 1'b0;
      for (int c = 0; c < NCH; c++)
        for (int t = 0; t < NTAPS; t++)
          hist[c][t] <= '0;
    end else begin
      s1_valid   <= 1'b0;
      p_valid    <= s1_valid;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      if (s1_valid) prod_q <= PW'(sample_q) * PW'(coeff);
      if (p_valid)  acc    <= acc + ACC_W'(prod_q);

      case (state)
        IDLE: begin
          // Samples addressed to a nonexistent channel are consumed silently.
          if (din_valid && ch_ok_c) begin
            for (int t = NTAPS - 1; t > 0; t--)
              hist[din_ch][t] <= hist[din_ch][t-1];
            hist[din_ch][0] <= datain;
            ch    <= din_ch;
            acc   <= '0;
            k     <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          sample_q <= hist[ch][k];
          s1_valid <= 1'b1;
          k        <= k + 1'b1;
          if (k == AW'(NTAPS - 1)) begin
            drain_cnt <= '0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == 2'd2) begin
            dataout    <= sat_c;
            overflow   <= clipped_c;
            dout_ch    <= ch;
            dout_valid <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mc_filter.sv
// Randomised self-checking bench for fir_mc_filter against a per-channel
// convolution model (NTAPS=8, NCH=3, OUT_SHIFT=1).
module tb_fir_mc_filter;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned COEF_W    = 18;
  localparam int unsigned NTAPS     = 8;
  localparam int unsigned NCH       = 3;
  localparam int unsigned OUT_SHIFT = 1;
  localparam int unsigned CHW       = 2;
  localparam int unsigned AW        = 3;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     din_valid;
  logic                     din_ready;
  logic [CHW-1:0]           din_ch;
  logic signed [DATA_W-1:0] datain;
  logic [AW-1:0]            coeffaddress;
  logic signed [COEF_W-1:0] coeff;
  logic                     dout_valid;
  logic [CHW-1:0]           dout_ch;
  logic signed [DATA_W-1:0] dataout;
  logic                     overflow;

  int     coef [NTAPS];
  longint hist_m [NCH][NTAPS];
  int     n_checks = 0;
  int     n_pass   = 0;

  fir_mc_filter #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .NCH(NCH), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clock(clock), .reset(reset), .din_valid(din_valid), .din_ready(din_ready),
    .din_ch(din_ch), .datain(datain), .coeffaddress(coeffaddress), .coeff(coeff),
    .dout_valid(dout_valid), .dout_ch(dout_ch), .dataout(dataout), .overflow(overflow)
  );

  always #5 clock = ~clock;

  // Synchronous coefficient ROM, one cycle of read latency.
  always @(posedge clock) coeff <= COEF_W'(coef[coeffaddress]);

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++)
      for (int t = 0; t < NTAPS; t++)
        hist_m[c][t] = 0;
  endtask

  task automatic model_push(input int c, input int d);
    for (int t = NTAPS - 1; t > 0; t--) hist_m[c][t] = hist_m[c][t-1];
    hist_m[c][0] = longint'(d);
  endtask

  // y = floor(sum/2 + 1/2), clipped to 16-bit signed.
  task automatic model_eval(input int c, output longint y, output longint o);
    longint s;
    s = 0;
    for (int t = 0; t < NTAPS; t++) s += hist_m[c][t] * longint'(coef[t]);
    y = (s + 1) >>> 1;
    o = 0;
    if (y > 32767) begin y = 32767; o = 1; end
    else if (y < -32768) begin y = -32768; o = 1; end
  endtask

  task automatic send(input int c, input int d);
    int     n;
    int     lat;
    int     strobes;
    longint ey;
    longint eo;
    n = 0;
    while (!din_ready && n < 40) begin @(posedge clock); #1; n++; end
    check("ready_wait", din_ready, 1);
    din_valid = 1'b1;
    din_ch    = CHW'(c);
    datain    = DATA_W'(d);
    @(posedge clock); #1;
    din_valid = 1'b0;
    if (c < NCH) begin
      model_push(c, d);
      model_eval(c, ey, eo);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
        @(posedge clock); #1;
        if (dout_valid) begin lat = i; break; end
      end
      check("latency", lat, NTAPS + 3);
      if (lat != 0) begin
        check("dataout", dataout, ey);
        check("dout_ch", dout_ch, c);
        check("overflow", overflow, eo);
        check("ready_with_strobe", din_ready, 1);
        @(posedge clock); #1;
        check("strobe_len", dout_valid, 0);
      end
    end else begin
      check("drop_ready", din_ready, 1);
      strobes = 0;
      for (int i = 0; i < NTAPS + 4; i++) begin
        @(posedge clock); #1;
        if (dout_valid) strobes++;
      end
      check("drop_strobe", strobes, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end

  initial begin
    int strobes;
    reset     = 1'b1;
    din_valid = 1'b0;
    din_ch    = '0;
    datain    = '0;
    for (int t = 0; t < NTAPS; t++) coef[t] = 0;
    model_clear();
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", din_ready, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_dataout", dataout, 0);
    check("rst_overflow", overflow, 0);
    check("rst_addr", coeffaddress, 0);
    check("rst_dout_ch", dout_ch, 0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", din_ready, 1);

    // Impulse on ch0 with c[k]=k+1 (includes acc=3 -> 2 rounding).
    for (int t = 0; t < NTAPS; t++) coef[t] = t + 1;
    send(0, 1);
    for (int i = 0; i < 7; i++) send(0, 0);

    // Interleave: impulse on ch1, constant 5 on ch0.
    for (int i = 0; i < 8; i++) begin
      send(1, (i == 0) ? 1 : 0);
      send(0, 5);
    end

    // Invalid channel is dropped; ch0 history must be untouched afterwards.
    send(3, 1234);
    send(0, 0);

    // Random traffic, including invalid channel 3.
    for (int t = 0; t < NTAPS; t++) coef[t] = int'($urandom_range(0, 8)) - 4;
    for (int i = 0; i < 40; i++)
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, 8191)) - 4096);

    // Saturation in both directions on ch2.
    for (int t = 0; t < NTAPS; t++) coef[t] = 131071;
    for (int i = 0; i < 8; i++) send(2, 32767);
    for (int i = 0; i < 8; i++) send(2, -32768);

    // Reset mid-MAC aborts the sample and clears all state.
    for (int t = 0; t < NTAPS; t++) coef[t] = t + 1;
    while (!din_ready) begin @(posedge clock); #1; end
    din_valid = 1'b1;
    din_ch    = 2'd1;
    datain    = 16'sd7;
    @(posedge clock); #1;
    din_valid = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    check("midrst_ready_low", din_ready, 0);
    reset = 1'b0;
    #1;
    check("midrst_ready", din_ready, 1);
    check("midrst_dataout", dataout, 0);
    check("midrst_overflow", overflow, 0);
    strobes = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clock); #1;
      if (dout_valid) strobes++;
    end
    check("midrst_no_strobe", strobes, 0);
    model_clear();
    send(1, 1);
    for (int i = 0; i < 3; i++) send(1, 0);
    send(2, 0);
    send(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
